cpu_tick_ctrl: RTL

Execution-rate controller for the on-board CPU: replaces the derived 1 Hz clock with a single-cycle clock-enable `tick` in the `CLOCK_50` domain, so every CPU register stays on one clock. Supports halt, free-run at a runtime-programmable period, debounced single-step from a push button, and stop-on-breakpoint. It also drives the heartbeat LED and a retired-tick counter for board debug.

---
 rtl/cpu_tick_ctrl_if.sv | 25 ++
 rtl/cpu_tick_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/cpu_tick_ctrl_if.sv
// CPU-facing control and status bundle of the tick controller.
// tick is a one-cycle strobe with no back-pressure; break_hit only counts in cycles where tick=1.
interface cpu_tick_ctrl_if #(
    parameter int CNT_W = 26
);
    logic [1:0]       mode;
    logic [CNT_W-1:0] period;
    logic             break_hit;
    logic             tick;
    logic             heartbeat;
    logic             running;
    logic             brk;
    logic [31:0]      tick_count;
    logic [1:0]       state_dbg;

    modport master (
        output mode, period, break_hit,
        input  tick, heartbeat, running, brk, tick_count, state_dbg
    );

    modport slave (
        input  mode, period, break_hit,
        output tick, heartbeat, running, brk, tick_count, state_dbg
    );
endinterface

// File: rtl/cpu_tick_ctrl.sv
// CPU execution-rate controller: issues a single-cycle clock enable in the CLOCK_50
// domain for halt, free-run, debounced single-step and stop-on-breakpoint operation.
module cpu_tick_ctrl #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int DB_W      = 20,
    parameter int CNT_W     = 26
) (
    input  logic           CLOCK_50,
    input  logic           KEY0,
    input  logic           step_key_n,
    cpu_tick_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        BREAK = 2'd3
    } state_t;

    localparam logic [1:0]      MODE_RUN  = 2'b01;
    localparam logic [1:0]      MODE_STEP = 2'b10;
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic             key_s1;
    logic             key_s2;
    logic             key_db;
    logic             key_db_q;
    logic [DB_W-1:0]  db_cnt;
    logic             press;
    logic [CNT_W-1:0] rate_cnt;
    logic [CNT_W-1:0] rate_last;
    logic             fire;
    logic             tick_d;
    logic             tick_q;
    logic             heartbeat_q;
    logic             running_q;
    logic             brk_q;
    logic [31:0]      tick_count_q;

    // The debounce counter only runs while the synced level disagrees with the
    // accepted level, so any return to the accepted level restarts the qualification.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            key_s1   <= 1'b1;
            key_s2   <= 1'b1;
            key_db   <= 1'b1;
            key_db_q <= 1'b1;
            db_cnt   <= '0;
        end else begin
            key_s1   <= step_key_n;
            key_s2   <= key_s1;
            key_db_q <= key_db;
            if (key_s2 == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                key_db <= key_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign press = key_db_q & ~key_db;

    // Live compare against the current period, so shortening it fires immediately.
    assign rate_last = (bus.period > CNT_W'(1)) ? bus.period - CNT_W'(1) : '0;
    assign fire      = (rate_cnt >= rate_last);

    always_comb begin
        state_next = state;
        tick_d     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mode == MODE_RUN)       state_next = RUN;
                else if (bus.mode == MODE_STEP) state_next = STEP;
            end
            RUN: begin
                if (bus.mode == MODE_STEP)          state_next = STEP;
                else if (bus.mode != MODE_RUN)      state_next = IDLE;
                else if (tick_q && bus.break_hit)   state_next = BREAK;
            end
            STEP: begin
                if (bus.mode == MODE_RUN)       state_next = RUN;
                else if (bus.mode != MODE_STEP) state_next = IDLE;
            end
            BREAK: begin
                if (bus.mode == MODE_STEP)     state_next = STEP;
                else if (bus.mode != MODE_RUN) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A tick is only issued if the block is still in the issuing state next cycle.
        if (state == RUN && state_next == RUN)   tick_d = fire;
        if (state == STEP && state_next == STEP) tick_d = press;
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state        <= IDLE;
            rate_cnt     <= '0;
            tick_q       <= 1'b0;
            heartbeat_q  <= 1'b0;
            running_q    <= 1'b0;
            brk_q        <= 1'b0;
            tick_count_q <= '0;
        end else begin
            state     <= state_next;
            rate_cnt  <= (state == RUN && state_next == RUN && !fire) ? rate_cnt + CNT_W'(1) : '0;
            tick_q    <= tick_d;
            running_q <= (state_next == RUN);
            brk_q     <= (state_next == BREAK);
            if (tick_d) begin
                heartbeat_q  <= ~heartbeat_q;
                tick_count_q <= tick_count_q + 32'd1;
            end
        end
    end

    assign bus.tick       = tick_q;
    assign bus.heartbeat  = heartbeat_q;
    assign bus.running    = running_q;
    assign bus.brk        = brk_q;
    assign bus.tick_count = tick_count_q;
    assign bus.state_dbg  = state;
endmodule
